// File: rtl/skolem_ctrl_pkg.sv
// Shared types and helpers for the bvsge(bvudiv(x, s), t) Skolem witness controller.
package skolem_ctrl_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        CHECK,
        RESP
    } state_e;

    // Largest positive w-bit two's-complement value.
    function automatic logic [MAX_W-1:0] cand_smax(input int unsigned w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] cand_ones(input int unsigned w);
        return (w >= MAX_W) ? '1 : (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Signed >= on zero-extended w-bit values: flipping the sign bit maps signed order onto unsigned order.
    function automatic logic sge(input logic [MAX_W-1:0] a,
                                 input logic [MAX_W-1:0] b,
                                 input int unsigned      w);
        logic [MAX_W-1:0] bias;
        bias = MAX_W'(1) << (w - 1);
        return (a ^ bias) >= (b ^ bias);
    endfunction

endpackage

// File: rtl/udiv_serial.sv
// Bit-serial restoring unsigned divider: one quotient bit per step, MSB first.
// A zero divisor yields an all-ones quotient because every trial subtraction succeeds.
module udiv_serial #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rem_o,
    output logic         last_c,
    output logic         done_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dq_q, dq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    trial;
    logic          fits;

    // dq holds the unconsumed dividend bits on the left and the quotient bits shifted in on the right.
    always_comb begin
        rem_d = rem_q;
        dq_d  = dq_q;
        cnt_d = cnt_q;
        trial = {rem_q, dq_q[W-1]};
        fits  = trial >= {1'b0, divisor_i};
        if (load_i) begin
            rem_d = '0;
            dq_d  = dividend_i;
            cnt_d = CW'(W);
        end else if (step_i && (cnt_q != '0)) begin
            if (fits) begin
                rem_d = W'(trial - {1'b0, divisor_i});
                dq_d  = {dq_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial[W-1:0];
                dq_d  = {dq_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            dq_q  <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o    = dq_q;
    assign rem_o  = rem_q;
    assign done_o = (cnt_q == '0);
    assign last_c = step_i && (cnt_q == CW'(1));

endmodule

// File: rtl/skolem_udiv_sge_ctrl.sv
// Sequential Skolem witness generator for bvsge(bvudiv(x, s), t), sharing one serial divider across candidates.
// Define SKOLEM_IC_CHECK_EN to cross-check each result against the closed-form invertibility condition.
module skolem_udiv_sge_ctrl
    import skolem_ctrl_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_s,
    input  logic [W-1:0] req_t,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_sat,
    output logic [W-1:0] rsp_x,
    output logic [W-1:0] rsp_q,
    output logic         ic_mismatch
);

    localparam logic [W-1:0] C1 = W'(cand_smax(W));
    localparam logic [W-1:0] C2 = W'(cand_ones(W));

    state_e       state_q;
    logic [W-1:0] s_q, t_q;
    logic         cand_idx_q;
    logic         req_ready_q, rsp_valid_q, rsp_sat_q;
    logic [W-1:0] rsp_x_q, rsp_q_q;

    logic         div_load, div_step, div_last, div_done;
    logic [W-1:0] cand, div_q, div_rem_unused;
    logic         q_ge_t;

    assign div_load = (state_q == LOAD);
    assign div_step = (state_q == DIV);
    assign cand     = cand_idx_q ? C2 : C1;
    assign q_ge_t   = sge(MAX_W'(div_q), MAX_W'(t_q), W);

    udiv_serial #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load_i    (div_load),
        .step_i    (div_step),
        .dividend_i(cand),
        .divisor_i (s_q),
        .q_o       (div_q),
        .rem_o     (div_rem_unused),
        .last_c    (div_last),
        .done_o    (div_done)
    );

    // C1 decides s<=1, C2 decides s>=2 and s=0, so trying both in order is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            t_q         <= '0;
            cand_idx_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_sat_q   <= 1'b0;
            rsp_x_q     <= '0;
            rsp_q_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        s_q         <= req_s;
                        t_q         <= req_t;
                        cand_idx_q  <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                LOAD: state_q <= DIV;
                DIV: begin
                    if (div_last) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (div_done) begin
                        rsp_q_q <= div_q;
                        if (q_ge_t) begin
                            rsp_sat_q   <= 1'b1;
                            rsp_x_q     <= cand;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else if (cand_idx_q) begin
                            rsp_sat_q   <= 1'b0;
                            rsp_x_q     <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            cand_idx_q <= 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sat   = rsp_sat_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_q     = rsp_q_q;

`ifdef SKOLEM_IC_CHECK_EN
    function automatic logic [W-1:0] udiv_smt(input logic [W-1:0] a, input logic [W-1:0] d);
        return (d == '0) ? '1 : a / d;
    endfunction

    logic ic_c;

    always_comb begin
        ic_c = sge(MAX_W'(udiv_smt(C2, s_q)), MAX_W'(t_q), W)
             | sge(MAX_W'(udiv_smt(C1, s_q)), MAX_W'(t_q), W);
    end

    assign ic_mismatch = rsp_valid_q & (ic_c != rsp_sat_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!ic_mismatch);
        end
    end
`else
    assign ic_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_skolem_udiv_sge_ctrl.sv
// Directed bench for skolem_udiv_sge_ctrl at W=4 with hand-computed witnesses, quotients and latencies.
module tb_skolem_udiv_sge_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_s;
    logic [3:0] req_t;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_sat;
    logic [3:0] rsp_x;
    logic [3:0] rsp_q;
    logic       ic_mismatch;

    int checks = 0;
    int errors = 0;

    skolem_udiv_sge_ctrl #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_s      (req_s),
        .req_t      (req_t),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sat    (rsp_sat),
        .rsp_x      (rsp_x),
        .rsp_q      (rsp_q),
        .ic_mismatch(ic_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to the response; optionally stall the consumer first.
    task automatic run_req(input string name, input logic [3:0] s, input logic [3:0] t,
                           input logic exp_sat, input logic [3:0] exp_x, input logic [3:0] exp_q,
                           input int exp_lat, input int hold);
        int cyc;
        @(negedge clk);
        check({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_s     = s;
        req_t     = t;
        @(negedge clk);
        cyc       = 1;
        req_valid = 1'b0;
        req_s     = 4'($urandom);
        req_t     = 4'($urandom);
        check({name, ".req_ready_busy"}, 32'(req_ready), 32'd0);
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
        check({name, ".sat"}, 32'(rsp_sat), 32'(exp_sat));
        check({name, ".x"}, 32'(rsp_x), 32'(exp_x));
        check({name, ".q"}, 32'(rsp_q), 32'(exp_q));
        check({name, ".ic"}, 32'(ic_mismatch), 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check({name, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, ".hold_ready"}, 32'(req_ready), 32'd0);
            check({name, ".hold_out"}, {23'd0, rsp_sat, rsp_x, rsp_q}, {23'd0, exp_sat, exp_x, exp_q});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        check({name, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int stale;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_s     = 4'h0;
        req_t     = 4'h0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.outs", {23'd0, rsp_sat, rsp_x, rsp_q}, 32'd0);
        check("rst.ic", 32'(ic_mismatch), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);

        // rsp_ready pulsed while idle must be harmless
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_ready", {30'd0, req_ready, rsp_valid}, 32'h2);

        run_req("s1_t7",  4'h1, 4'h7, 1'b1, 4'h7, 4'h7, 7,  0);
        run_req("s2_t7",  4'h2, 4'h7, 1'b1, 4'hF, 4'h7, 13, 0);
        run_req("s0_tm1", 4'h0, 4'hF, 1'b1, 4'h7, 4'hF, 7,  0);
        run_req("s0_t0",  4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 13, 0);
        run_req("s3_t6",  4'h3, 4'h6, 1'b0, 4'h0, 4'h5, 13, 0);
        run_req("s1_tm8", 4'h1, 4'h8, 1'b1, 4'h7, 4'h7, 7,  0);
        run_req("s15_t1", 4'hF, 4'h1, 1'b1, 4'hF, 4'h1, 13, 5);

        // Abandon a request mid-division via reset
        @(negedge clk);
        req_valid = 1'b1;
        req_s     = 4'h2;
        req_t     = 4'h7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst.req_ready", 32'(req_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        check("midrst.stale", 32'(stale), 32'd0);
        run_req("after_rst", 4'h1, 4'h0, 1'b1, 4'h7, 4'h7, 7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
